// File: rtl/aud_rmm_target.sv
// ---------------------------------------------------------------------------
// aud_rmm_target
//
// Target-side responder for the AUD RAM-monitor (RMM) nibble protocol.
// It plays the MCU end of the link. It decodes the host command, address and
// write-data nibbles and performs the access on a simple memory request port.
// It then answers with busy nibbles, a status nibble and, for successful
// reads, the read-data nibbles. The host and the target share clk_sys_i, so
// there is no separate aud_ck input.
//
// Parameters
//   MIN_BUSY        busy (0000) nibbles always driven before the status (1..15)
//   TIMEOUT_CYCLES  cycles without mem_ack_i before a request is abandoned
//
// Optional feature
//   AUD_RMM_TARGET_TIMEOUT_EN  when defined, an outstanding memory request is
//                              dropped after TIMEOUT_CYCLES cycles and status
//                              1001 is returned; otherwise the target waits
//                              for the ack indefinitely.
//
// Ports
//   clk_sys_i      system clock, doubles as aud_ck
//   rst_n_i        asynchronous active-low reset
//   aud_nsync_i    host frame strobe, low while a frame is active
//   aud_data_i     host-driven nibble
//   aud_data_o     responder nibble
//   aud_data_oe_o  responder drives aud_data (tristate lives at the top level)
//   mem_addr_o     access address
//   mem_dat_o      write data, placed in the selected byte lanes
//   mem_sel_o      byte enables
//   mem_we_o       write request
//   mem_re_o       read request
//   mem_dat_i      read data
//   mem_ack_i      access complete
//   mem_err_i      access failed, qualified by mem_ack_i
//   busy_o         a frame is in progress
//   err_cnt_o      saturating count of error statuses returned
// ---------------------------------------------------------------------------
module aud_rmm_target #(
  parameter int unsigned MIN_BUSY       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        aud_nsync_i,
  input  logic [3:0]  aud_data_i,
  output logic [3:0]  aud_data_o,
  output logic        aud_data_oe_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dat_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  output logic        busy_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WDATA, S_TURN, S_BUSY,
    S_READY, S_RDATA, S_DONE, S_DROP, S_FLUSH
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [1:0]  size_q;
  logic        is_write_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;
  logic        req_q, done_q, err_q, misaligned_q, status_err_q;
  logic [7:0]  err_cnt_q;

  logic        cmd_ok, ack_now, tmo_now, complete_now, busy_met;
  logic        misaligned_c, status_err_now;
  logic [3:0]  sel_calc;
  logic [1:0]  lane_base;
  logic [2:0]  last_idx, pos;

  // A command nibble is 1wss: bit 2 selects write, ss = 11 is reserved.
  assign cmd_ok  = aud_data_i[3] && (aud_data_i[1:0] != 2'b11);
  assign ack_now = req_q && mem_ack_i;

  // Lane placement and nibble count derived from size and low address bits.
  always_comb begin
    sel_calc  = 4'b1111;
    lane_base = 2'b00;
    last_idx  = 3'd7;
    case (size_q)
      2'b00: begin
        sel_calc  = 4'b0001 << addr_q[1:0];
        lane_base = addr_q[1:0];
        last_idx  = 3'd1;
      end
      2'b01: begin
        sel_calc  = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_base = {addr_q[1], 1'b0};
        last_idx  = 3'd3;
      end
      default: begin
        sel_calc  = 4'b1111;
        lane_base = 2'b00;
        last_idx  = 3'd7;
      end
    endcase
  end

  // Nibble position inside the 32-bit data word: first nibble of the lane.
  assign pos = {lane_base, 1'b0} + cnt[2:0];

  assign misaligned_c = ((size_q == 2'b01) && addr_q[0]) ||
                        ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));

`ifdef AUD_RMM_TARGET_TIMEOUT_EN
  // Counts cycles a request has been outstanding; cleared whenever idle.
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt <= '0;
    end else if (!req_q) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != 16'hFFFF) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_now = req_q && !mem_ack_i &&
                   ((32'(tmo_cnt) + 32'd1) >= TIMEOUT_CYCLES);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_now        = 1'b0;
`endif

  // The status may be decided on the same edge the ack (or timeout) lands.
  assign complete_now   = misaligned_q || done_q || ack_now || tmo_now;
  assign busy_met       = (32'(cnt) + 32'd1) >= MIN_BUSY;
  assign status_err_now = misaligned_q ||
                          (done_q ? err_q : (tmo_now || (ack_now && mem_err_i)));

  // Next state and link-side outputs. Raising nsync mid-frame aborts; an
  // outstanding request is then carried to completion in FLUSH.
  always_comb begin
    state_nxt     = state;
    aud_data_oe_o = 1'b0;
    aud_data_o    = 4'h0;
    case (state)
      S_IDLE: begin
        if (!aud_nsync_i) state_nxt = cmd_ok ? S_ADDR : S_DROP;
      end
      S_ADDR: begin
        if (aud_nsync_i)          state_nxt = S_IDLE;
        else if (cnt == 4'd7)     state_nxt = is_write_q ? S_WDATA : S_TURN;
      end
      S_WDATA: begin
        if (aud_nsync_i)                    state_nxt = S_IDLE;
        else if (cnt == {1'b0, last_idx})   state_nxt = S_TURN;
      end
      S_TURN, S_BUSY, S_READY, S_RDATA: begin
        if (state == S_BUSY) aud_data_oe_o = 1'b1;
        if (state == S_READY) begin
          aud_data_oe_o = 1'b1;
          aud_data_o    = status_err_q ? 4'b1001 : 4'b0001;
        end
        if (state == S_RDATA) begin
          aud_data_oe_o = 1'b1;
          aud_data_o    = rdata_q[{pos, 2'b00} +: 4];
        end
        if (aud_nsync_i) begin
          state_nxt = (req_q && !ack_now && !tmo_now) ? S_FLUSH : S_IDLE;
        end else begin
          case (state)
            S_TURN:  state_nxt = S_BUSY;
            S_BUSY:  if (busy_met && complete_now) state_nxt = S_READY;
            S_READY: state_nxt = (!is_write_q && !status_err_q) ? S_RDATA : S_DONE;
            default: if (cnt == {1'b0, last_idx}) state_nxt = S_DONE;
          endcase
        end
      end
      S_DONE, S_DROP: begin
        if (aud_nsync_i) state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        // A frame started while flushing is swallowed as if it were illegal.
        if (!req_q || ack_now || tmo_now) state_nxt = aud_nsync_i ? S_IDLE : S_DROP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, nibble counter, frame registers and the memory request handshake.
  // The counter restarts on every state change so each phase counts from 0.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      size_q       <= '0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      sel_q        <= '0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      misaligned_q <= 1'b0;
      status_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != 4'hF)   cnt <= cnt + 4'd1;

      case (state)
        S_IDLE: begin
          if (!aud_nsync_i && cmd_ok) begin
            is_write_q <= aud_data_i[2];
            size_q     <= aud_data_i[1:0];
            wdata_q    <= '0;
          end
        end
        S_ADDR: begin
          addr_q[{cnt[2:0], 2'b00} +: 4] <= aud_data_i;
          if (cnt == 4'd7) sel_q <= sel_calc;
        end
        S_WDATA: begin
          wdata_q[{pos, 2'b00} +: 4] <= aud_data_i;
        end
        default: begin
        end
      endcase

      if ((state == S_ADDR || state == S_WDATA) && state_nxt == S_TURN) begin
        req_q        <= !misaligned_c;
        misaligned_q <= misaligned_c;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
      end else if (ack_now || tmo_now) begin
        req_q  <= 1'b0;
        done_q <= 1'b1;
        err_q  <= tmo_now || mem_err_i;
        if (ack_now) rdata_q <= mem_dat_i;
      end

      // The status is fixed when READY is entered; aborted frames never count.
      if (state == S_BUSY && state_nxt == S_READY) begin
        status_err_q <= status_err_now;
        if (status_err_now && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_dat_o  = wdata_q;
  assign mem_sel_o  = sel_q;
  assign mem_we_o   = req_q && is_write_q;
  assign mem_re_o   = req_q && !is_write_q;
  assign busy_o     = (state != S_IDLE);
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_aud_rmm_target.sv
// ---------------------------------------------------------------------------
// tb_aud_rmm_target
//
// Host-side model for aud_rmm_target. Each table entry is one frame; the
// expected memory access and the expected response nibbles are queued when
// the frame is driven and consumed when the DUT issues its request or
// returns nibbles.
// ---------------------------------------------------------------------------
module tb_aud_rmm_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nsync;
  logic [3:0]  din;
  logic [3:0]  dout;
  logic        oe;
  logic [31:0] mem_addr, mem_wdat, mem_rdat;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_re, mem_ack, mem_err, busy;
  logic [7:0]  err_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_err = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wval;
    logic [31:0] rdat;
    logic        err;
    int          delay;
    logic        acc;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [3:0]  status;
    logic [31:0] rnibs;
    int          min_busy;
    int          mode;
  } frame_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        err;
    int          delay;
  } mem_txn_t;

  mem_txn_t   mem_q[$];
  logic [3:0] resp_q[$];
  frame_t     tbl[0:13];

  aud_rmm_target #(.MIN_BUSY(2), .TIMEOUT_CYCLES(8)) dut (
    .clk_sys_i    (clk),
    .rst_n_i      (rst_n),
    .aud_nsync_i  (nsync),
    .aud_data_i   (din),
    .aud_data_o   (dout),
    .aud_data_oe_o(oe),
    .mem_addr_o   (mem_addr),
    .mem_dat_o    (mem_wdat),
    .mem_sel_o    (mem_sel),
    .mem_we_o     (mem_we),
    .mem_re_o     (mem_re),
    .mem_dat_i    (mem_rdat),
    .mem_ack_i    (mem_ack),
    .mem_err_i    (mem_err),
    .busy_o       (busy),
    .err_cnt_o    (err_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case a wait somewhere is not bounded as intended.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: checks each new request against the queue and acks it
  // after the requested number of cycles. A one-cycle ack is always dropped
  // on the following cycle.
  logic     m_busy = 1'b0;
  int       m_wait = 0;
  mem_txn_t m_cur;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
    end else if (mem_we || mem_re) begin
      if (!m_busy) begin
        if (mem_q.size() == 0) begin
          checkOutput("unexpected_req", {30'd0, mem_we, mem_re}, 32'd0);
          m_cur = '{32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1000000};
        end else begin
          m_cur = mem_q.pop_front();
          checkOutput("req_addr", mem_addr, m_cur.addr);
          checkOutput("req_sel", {28'd0, mem_sel}, {28'd0, m_cur.sel});
          checkOutput("req_dir", {30'd0, mem_we, mem_re}, {30'd0, m_cur.we, !m_cur.we});
          if (m_cur.we) checkOutput("req_wdat", mem_wdat, m_cur.wdat);
        end
        m_busy = 1'b1;
        m_wait = 0;
      end
      if (m_wait >= m_cur.delay) begin
        mem_ack  = 1'b1;
        mem_err  = m_cur.err;
        mem_rdat = m_cur.rdat;
        m_busy   = 1'b0;
      end else begin
        m_wait++;
      end
    end else begin
      m_busy = 1'b0;
    end
  end

  // Drives one frame and collects the response. mode 0 = normal,
  // 1 = abort by raising nsync after two busy nibbles, 2 = async reset there.
  task automatic applyStimulus(input frame_t c);
    int n, busy_seen, k;
    logic w;
    n = 2 << int'(c.cmd[1:0]);
    w = c.cmd[2];
    if (c.acc) mem_q.push_back('{c.addr, c.sel, w, c.wdat, c.rdat, c.err, c.delay});
    if (c.mode == 0) begin
      resp_q.push_back(c.status);
      if (!w && c.status == 4'b0001)
        for (int i = 0; i < n; i++) resp_q.push_back(c.rnibs[4*i +: 4]);
      if (c.status == 4'b1001) exp_err++;
    end

    @(negedge clk);
    nsync = 1'b0;
    din   = c.cmd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din = c.addr[4*i +: 4];
    end
    if (w) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        din = c.wval[4*i +: 4];
      end
    end
    @(negedge clk);
    din = 4'h0;
    checkOutput("turn_oe", {31'd0, oe}, 32'd0);

    busy_seen = 0;
    k = 0;
    @(negedge clk);
    while (oe === 1'b1 && dout === 4'h0 && k < 400 && !(c.mode != 0 && busy_seen == 2)) begin
      busy_seen++;
      k++;
      @(negedge clk);
    end
    checkOutput("busy_bound", (k < 400) ? 32'd1 : 32'd0, 32'd1);

    if (c.mode == 0) begin
      checkOutput("busy_min", (busy_seen >= c.min_busy) ? c.min_busy : busy_seen, c.min_busy);
      while (resp_q.size() > 0) begin
        logic [3:0] e;
        e = resp_q.pop_front();
        checkOutput("resp_oe", {31'd0, oe}, 32'd1);
        checkOutput("resp_nib", {28'd0, dout}, {28'd0, e});
        @(negedge clk);
      end
      checkOutput("done_oe", {31'd0, oe}, 32'd0);
      checkOutput("err_cnt", {24'd0, err_cnt}, exp_err);
      nsync = 1'b1;
    end else if (c.mode == 1) begin
      nsync = 1'b1;
      @(negedge clk);
      checkOutput("abort_oe", {31'd0, oe}, 32'd0);
      checkOutput("abort_req_held", {31'd0, mem_re | mem_we}, 32'd1);
      k = 0;
      while ((mem_re || mem_we) && k < 50) begin
        k++;
        @(negedge clk);
      end
      checkOutput("flush_bound", (k < 50) ? 32'd1 : 32'd0, 32'd1);
      checkOutput("flush_err_cnt", {24'd0, err_cnt}, exp_err);
      checkOutput("flush_idle", {31'd0, busy}, 32'd0);
    end else begin
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req", {30'd0, mem_we, mem_re}, 32'd0);
      checkOutput("rst_oe", {31'd0, oe}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      exp_err = 0;
      @(negedge clk);
      rst_n = 1'b1;
      nsync = 1'b1;
      @(negedge clk);
    end
  endtask

  // Illegal command: the target must stay silent and touch no memory.
  task automatic applyIllegal();
    int oe_cnt, req_cnt;
    oe_cnt  = 0;
    req_cnt = 0;
    @(negedge clk);
    nsync = 1'b0;
    din   = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (oe) oe_cnt++;
      if (mem_we || mem_re) req_cnt++;
      din = 4'($urandom_range(0, 15));
    end
    checkOutput("drop_oe_cnt", oe_cnt, 0);
    checkOutput("drop_req_cnt", req_cnt, 0);
    checkOutput("drop_busy", {31'd0, busy}, 32'd1);
    nsync = 1'b1;
    @(negedge clk);
    checkOutput("drop_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    //                cmd    addr          wval          rdat          err delay acc sel    wdat          st     rnibs        minb mode
    tbl[0]  = '{4'hE, 32'h00001000, 32'hDEADBEEF, 32'h0,        1'b0, 5,  1'b1, 4'hF, 32'hDEADBEEF, 4'h1, 32'h0,        5,   0};
    tbl[1]  = '{4'h8, 32'h00000203, 32'h0,        32'hA5000000, 1'b0, 0,  1'b1, 4'h8, 32'h0,        4'h1, 32'h000000A5, 2,   0};
    tbl[2]  = '{4'hD, 32'h00000001, 32'h0000BEEF, 32'h0,        1'b0, 0,  1'b0, 4'h0, 32'h0,        4'h9, 32'h0,        2,   0};
    tbl[3]  = '{4'hA, 32'h00002000, 32'h0,        32'h89ABCDEF, 1'b0, 1,  1'b1, 4'hF, 32'h0,        4'h1, 32'h89ABCDEF, 2,   0};
    tbl[4]  = '{4'hC, 32'h00000102, 32'h0000003C, 32'h0,        1'b0, 2,  1'b1, 4'h4, 32'h003C0000, 4'h1, 32'h0,        2,   0};
    tbl[5]  = '{4'h9, 32'h00000202, 32'h0,        32'h12345678, 1'b0, 3,  1'b1, 4'hC, 32'h0,        4'h1, 32'h00001234, 2,   0};
    tbl[6]  = '{4'hD, 32'h00000004, 32'h0000BEEF, 32'h0,        1'b0, 0,  1'b1, 4'h3, 32'h0000BEEF, 4'h1, 32'h0,        2,   0};
    tbl[7]  = '{4'hA, 32'h00000010, 32'h0,        32'h0,        1'b1, 2,  1'b1, 4'hF, 32'h0,        4'h9, 32'h0,        2,   0};
    tbl[8]  = '{4'hA, 32'h00000002, 32'h0,        32'h0,        1'b0, 0,  1'b0, 4'h0, 32'h0,        4'h9, 32'h0,        2,   0};
    tbl[9]  = '{4'hA, 32'h00000030, 32'h0,        32'h0,        1'b0, 10, 1'b1, 4'hF, 32'h0,        4'h1, 32'h0,        2,   1};
    tbl[10] = '{4'h9, 32'h00000040, 32'h0,        32'h0000CAFE, 1'b0, 0,  1'b1, 4'h3, 32'h0,        4'h1, 32'h0000CAFE, 2,   0};
`ifdef AUD_RMM_TARGET_TIMEOUT_EN
    tbl[11] = '{4'hA, 32'h00000070, 32'h0,        32'h0,        1'b0, 1000, 1'b1, 4'hF, 32'h0,      4'h9, 32'h0,        2,   0};
`else
    tbl[11] = '{4'hA, 32'h00000070, 32'h0,        32'h0BADF00D, 1'b0, 110, 1'b1, 4'hF, 32'h0,       4'h1, 32'h0BADF00D, 100, 0};
`endif
    tbl[12] = '{4'hE, 32'h00000050, 32'h11223344, 32'h0,        1'b0, 50, 1'b1, 4'hF, 32'h11223344, 4'h1, 32'h0,        2,   2};
    tbl[13] = '{4'h8, 32'h00000061, 32'h0,        32'h00005A00, 1'b0, 0,  1'b1, 4'h2, 32'h0,        4'h1, 32'h0000005A, 2,   0};

    rst_n    = 1'b0;
    nsync    = 1'b1;
    din      = 4'h0;
    mem_ack  = 1'b0;
    mem_err  = 1'b0;
    mem_rdat = 32'h0;
    #3;
    checkOutput("reset_oe", {31'd0, oe}, 32'd0);
    checkOutput("reset_req", {30'd0, mem_we, mem_re}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (i == 3) applyIllegal();
      applyStimulus(tbl[i]);
    end

    repeat (4) @(negedge clk);
    checkOutput("final_err_cnt", {24'd0, err_cnt}, exp_err);
    checkOutput("mem_q_left", mem_q.size(), 32'd0);
    checkOutput("resp_q_left", resp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
